// File: rtl/bcd_pkg.sv
// Shared constants, state type and per-digit clamp helper for the BCD
// down-counter family.
package bcd_pkg;

  localparam int         BCD_W   = 4;
  localparam logic [3:0] BCD_MAX = 4'd9;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    EXPIRE
  } bcd_dn_state_t;

  // Nibbles A-F are not valid BCD; they saturate to 9.
  function automatic logic [BCD_W-1:0] bcd_clamp(input logic [BCD_W-1:0] d);
    return (d > BCD_MAX) ? BCD_MAX : d;
  endfunction

endpackage

// File: rtl/bcd_down_counter_if.sv
// Control/status bundle of the BCD down-counter: the master side loads and
// enables, the slave side (the counter) reports count and flags.
interface bcd_down_counter_if #(
  parameter int DIGITS = 4
);
  import bcd_pkg::*;

  logic                    load;
  logic [BCD_W*DIGITS-1:0] load_val;
  logic                    en;
  logic [BCD_W*DIGITS-1:0] cnt;
  logic                    busy;
  logic                    zero;
  logic                    done;

  modport master (
    output load, load_val, en,
    input  cnt, busy, zero, done
  );

  modport slave (
    input  load, load_val, en,
    output cnt, busy, zero, done
  );

endinterface

// File: rtl/bcd_digit_dec.sv
// One BCD digit of the decrement chain: passes the digit through unless a
// borrow arrives, in which case 0 wraps to 9 and the borrow continues upward.
module bcd_digit_dec
  import bcd_pkg::*;
(
  input  logic [BCD_W-1:0] d_in,
  input  logic             borrow_in,
  output logic [BCD_W-1:0] d_out,
  output logic             borrow_out
);

  always_comb begin
    d_out = d_in;
    if (borrow_in) begin
      d_out = (d_in == '0) ? BCD_MAX : (d_in - 4'd1);
    end
  end

  assign borrow_out = borrow_in && (d_in == '0);

endmodule

// File: rtl/bcd_down_counter.sv
// Multi-digit BCD countdown timer: clamped preset load, one decrement per
// enabled cycle in RUN, single-cycle EXPIRE state driving the done pulse.
module bcd_down_counter
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic               clk,
  input  logic               rst,
  bcd_down_counter_if.slave  bus
);

  localparam int W = BCD_W * DIGITS;
  localparam logic [W-1:0] CNT_ONE = W'(1);

  bcd_dn_state_t state_q, state_d;
  logic [W-1:0]  cnt_q, cnt_d;
  logic [W-1:0]  load_san;
  logic [W-1:0]  dec_val;
  logic [DIGITS:0] borrow;

  // Digit 0 always receives a borrow; a borrow leaving the top digit can only
  // happen when every digit is 0, so it doubles as the zero detector.
  assign borrow[0] = 1'b1;

  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
    assign load_san[gi*BCD_W +: BCD_W] = bcd_clamp(bus.load_val[gi*BCD_W +: BCD_W]);

    bcd_digit_dec u_dec (
      .d_in       (cnt_q[gi*BCD_W +: BCD_W]),
      .borrow_in  (borrow[gi]),
      .d_out      (dec_val[gi*BCD_W +: BCD_W]),
      .borrow_out (borrow[gi+1])
    );
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (bus.load) begin
      cnt_d   = load_san;
      state_d = (load_san != '0) ? RUN : IDLE;
    end else begin
      case (state_q)
        RUN: begin
          if (bus.en) begin
            cnt_d = dec_val;
            if (cnt_q == CNT_ONE) begin
              state_d = EXPIRE;
            end
          end
        end
        EXPIRE:  state_d = IDLE;
        IDLE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.cnt  = cnt_q;
  assign bus.busy = (state_q == RUN);
  assign bus.zero = borrow[DIGITS];
  assign bus.done = (state_q == EXPIRE);

endmodule

// File: tb/tb_bcd_down_counter.sv
// Randomised and directed bench for bcd_down_counter against an integer
// countdown model (decimal value, running flag, expiry flag).
module tb_bcd_down_counter;

  localparam int D = 4;
  localparam int W = 4 * D;

  logic clk;
  logic rst;
  bit   clk_en;

  bcd_down_counter_if #(.DIGITS(D)) bus ();

  bcd_down_counter #(.DIGITS(D)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = clk_en ? ~clk : 1'b0;

  int n_cmp;
  int n_err;

  int m_val;
  bit m_run;
  bit m_done;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int san_int(input logic [W-1:0] v);
    int r = 0;
    int p = 1;
    for (int i = 0; i < D; i++) begin
      int d = int'(v[4*i +: 4]);
      if (d > 9) d = 9;
      r += d * p;
      p *= 10;
    end
    return r;
  endfunction

  function automatic logic [W-1:0] to_bcd(input int v);
    logic [W-1:0] r = '0;
    int x = v;
    for (int i = 0; i < D; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  task automatic model_reset();
    m_val  = 0;
    m_run  = 0;
    m_done = 0;
  endtask

  task automatic model_step();
    if (bus.load) begin
      m_val  = san_int(bus.load_val);
      m_run  = (m_val != 0);
      m_done = 0;
    end else if (m_run && bus.en) begin
      m_val  = m_val - 1;
      m_done = (m_val == 0);
      if (m_val == 0) m_run = 0;
    end else begin
      m_done = 0;
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".cnt"},  32'(bus.cnt),  32'(to_bcd(m_val)));
    check({tag, ".busy"}, 32'(bus.busy), 32'(m_run));
    check({tag, ".zero"}, 32'(bus.zero), 32'(m_val == 0));
    check({tag, ".done"}, 32'(bus.done), 32'(m_done));
  endtask

  // Inputs are set before the call and only change again 1 time unit after
  // the edge, so the model sees exactly what the DUT sampled.
  task automatic tick(input string tag);
    @(posedge clk);
    model_step();
    #1;
    check_all(tag);
  endtask

  task automatic drive(input bit ld, input logic [W-1:0] val, input bit e);
    bus.load     = ld;
    bus.load_val = val;
    bus.en       = e;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    clk_en = 1'b0;
    rst = 1'b0;
    drive(0, '0, 0);
    model_reset();

    // Reset with the clock stopped.
    #2 rst = 1'b1;
    #1;
    check("rst_noclk.cnt",  32'(bus.cnt),  32'h0);
    check("rst_noclk.zero", 32'(bus.zero), 32'h1);
    check("rst_noclk.busy", 32'(bus.busy), 32'h0);
    check("rst_noclk.done", 32'(bus.done), 32'h0);
    clk_en = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    tick("idle");

    // Borrow chain across all digits.
    drive(1, 16'h1000, 1);
    tick("bor_load");
    check("bor_load_cnt", 32'(bus.cnt), 32'h1000);
    drive(0, '0, 1);
    tick("bor_1");
    check("bor_first", 32'(bus.cnt), 32'h0999);
    for (int i = 2; i <= 1000; i++) tick("bor_run");
    check("bor_end_cnt",  32'(bus.cnt),  32'h0);
    check("bor_end_done", 32'(bus.done), 32'h1);
    tick("bor_post");
    check("bor_post_done", 32'(bus.done), 32'h0);
    check("bor_post_busy", 32'(bus.busy), 32'h0);

    // Pause.
    drive(1, 16'h0005, 0);
    tick("pause_load");
    drive(0, '0, 1);
    tick("pause_e1");
    tick("pause_e2");
    drive(0, '0, 0);
    for (int i = 0; i < 3; i++) begin
      tick("pause_hold");
      check("pause_hold_cnt", 32'(bus.cnt), 32'h3);
    end
    drive(0, '0, 1);
    for (int i = 0; i < 3; i++) begin
      tick("pause_resume");
      check("pause_done", 32'(bus.done), 32'(i == 2));
    end
    tick("pause_post");

    // Clamp.
    drive(1, 16'h0A3F, 0);
    tick("clamp");
    check("clamp_cnt", 32'(bus.cnt), 32'h0939);

    // Load of zero while running.
    drive(1, 16'h0050, 1);
    tick("lz_run");
    drive(1, 16'h0000, 1);
    tick("lz_load");
    check("lz_busy", 32'(bus.busy), 32'h0);
    check("lz_cnt",  32'(bus.cnt),  32'h0);
    drive(0, '0, 1);
    tick("lz_after");
    check("lz_nodone", 32'(bus.done), 32'h0);

    // Load colliding with expiry.
    drive(1, 16'h0002, 1);
    tick("col_load");
    drive(0, '0, 1);
    tick("col_dec");
    check("col_one", 32'(bus.cnt), 32'h1);
    drive(1, 16'h0020, 1);
    tick("col_hit");
    check("col_cnt",  32'(bus.cnt),  32'h0020);
    check("col_busy", 32'(bus.busy), 32'h1);
    check("col_done", 32'(bus.done), 32'h0);
    drive(0, '0, 0);
    tick("col_after");

    // Reset mid-run, asserted between edges.
    drive(1, 16'h0457, 0);
    tick("mid_load");
    #2 rst = 1'b1;
    #1;
    model_reset();
    check("mid_rst_cnt",  32'(bus.cnt),  32'h0);
    check("mid_rst_busy", 32'(bus.busy), 32'h0);
    check("mid_rst_zero", 32'(bus.zero), 32'h1);
    @(posedge clk);
    #1 rst = 1'b0;
    drive(0, '0, 1);
    for (int i = 0; i < 10; i++) tick("mid_after");
    check("mid_end_cnt",  32'(bus.cnt),  32'h0);
    check("mid_end_busy", 32'(bus.busy), 32'h0);

    // Random traffic.
    for (int i = 0; i < 4000; i++) begin
      bit ld = ($urandom_range(0, 19) == 0);
      logic [W-1:0] v;
      if ($urandom_range(0, 1) == 0) v = to_bcd(int'($urandom_range(0, 40)));
      else v = W'($urandom);
      drive(ld, v, ($urandom_range(0, 3) != 0));
      tick("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/bcd_down_counter.md
# bcd_down_counter

Multi-digit BCD down-counter (countdown timer): the decrementing counterpart of the team's single-digit BCD up-counter. Loads a packed BCD value, decrements one count per enabled clock with digit-wise borrow (…10 → …09), and flags expiry with a one-cycle `done` pulse. Used as the timeout/interval source beside the up-counter in the counter test chip.

## Interface
- `DIGITS`, default 4: number of BCD digits. Legal values are 1..8.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous reset, active-high.
- `load`  in  1  when high, captures `load_val` at the next edge.
- `load_val`  in  4*DIGITS  packed BCD preset. Digit 0 is in bits [3:0].
- `en`  in  1  count enable. Decrements only while the block is in RUN.
- `cnt`  out  4*DIGITS  current packed BCD count.
- `busy`  out  1  high while in RUN.
- `zero`  out  1  high when `cnt` is 0.
- `done`  out  1  one-cycle pulse on expiry.

## Operation
- The FSM has three states: IDLE, RUN and EXPIRE. Its state is registered.
- Reset values: state IDLE, `cnt` = 0, `busy` = 0, `zero` = 1, `done` = 0.
- Load sanitising: any loaded digit greater than 9 (nibble A–F) is clamped to 9 before it is stored. The clamp applies per digit.
- `load` has priority over decrement in every state.
  - Sanitised value nonzero: `cnt` takes that value and the next state is RUN.
  - Sanitised value zero: `cnt` becomes 0, the next state is IDLE, and `done` does not pulse.
- RUN with `en` = 1 and no load:
  - `cnt` decrements by 1 in BCD.
  - Digit 0 decrements. Any digit at 0 becomes 9 and borrows from the next digit up.
  - If `cnt` is 1 before the edge, `cnt` becomes 0 and the next state is EXPIRE.
- RUN with `en` = 0: `cnt` holds. This is a pause, and RUN is kept.
- EXPIRE lasts exactly 1 cycle, then the FSM goes to IDLE.
  - A `load` that arrives during EXPIRE is honoured under the priority rule above.
- IDLE: `cnt` holds at its value (0 after expiry). `en` is ignored.
- `cnt` never wraps below 0. RUN is always left on reaching zero.
- Outputs:
  - `busy` = (state == RUN).
  - `zero` = (`cnt` == 0).
  - `done` = (state == EXPIRE).
  - All outputs are registered or derived from registers only. None depends combinationally on any input.

## Timing
- `load` at edge N: `cnt` = preset and `busy` = 1 from N. The first decrement happens at edge N+1 if `en` is high.
- A preset of V with `en` held high reaches `cnt` = 0 at edge N+V.
  - `done` is high for the single cycle following edge N+V.
  - `busy` falls at edge N+V.
- Digit borrows ripple within one cycle. There is no multi-cycle borrow.
- `rst` asserted mid-count forces all outputs to their reset values immediately, without waiting for a clock edge.
  - After release, the block stays in IDLE until a `load` arrives.
- Reset release must be synchronised externally to `clk`.
- Simultaneous `load` and expiry (`cnt` = 1, `en` = 1, `load` = 1): the load wins. No EXPIRE and no `done` occur.

## Structure
- Package `bcd_pkg` holds the shared constants and state type:
  - `BCD_W` = 4 and `BCD_MAX` = 4'd9.
  - The state enum `bcd_dn_state_t` {IDLE, RUN, EXPIRE}.
  - `bcd_clamp()`, the per-digit clamp function.
- Sub-module `bcd_digit_dec` is combinational and instantiated DIGITS times, chained by borrow:
  - Inputs: `d_in[3:0]`, `borrow_in`.
  - Outputs: `d_out[3:0]`, `borrow_out`.
  - `borrow_out` = `borrow_in` && (`d_in` == 0).
- The top level holds the FSM, the `cnt` register, the load mux and the output flags.

## Test plan
- Reset: assert `rst` with no clock running. Required: `cnt` = 0, `zero` = 1, `busy` = 0, `done` = 0 asynchronously.
- Borrow chain (DIGITS = 4): load 0x1000, `en` = 1.
  - After 1 edge: `cnt` = 0x0999.
  - After 1000 edges: `cnt` = 0x0000, with `done` high for exactly 1 cycle and `busy` low after it.
- Pause: load 0x0005, then `en` = 1 for 2 edges, 0 for 3 edges, 1 again.
  - Required: `cnt` goes 5 → 3 and holds at 3 for 3 cycles.
  - `done` fires on the 5th enabled edge, not before.
- Clamp: load 0x0A3F. Required: `cnt` = 0x0939.
- Load of zero: load 0x0000 while in RUN. Required: IDLE, `cnt` = 0, no `done`.
- Load/expiry collision: with `cnt` = 0x0001, `en` = 1, load 0x0020 on the same edge.
  - Required: `cnt` = 0x0020, `busy` stays 1, no `done`.
- Reset mid-run: assert `rst` with `cnt` = 0x0457.
  - Required: `cnt` = 0 immediately.
  - After release, `en` = 1 for 10 edges leaves `cnt` = 0 and `busy` = 0.
